// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Purpose  : Single-outstanding Wishbone classic master. Converts a
//            valid/ready command stream into one bus cycle at a time and
//            returns read data, or a timeout error when no ack arrives.
// Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // command stream
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    // response stream
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    // Wishbone master port
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUS  = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    // TIMEOUT is limited to 1..255, so the 8-bit compare value is exact
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [1:0] r_state;
    logic [7:0] r_count;   // 1 in the first BUS cycle, never wraps

    // Commands are only taken while nothing is in flight
    assign req_ready = (r_state == c_S_IDLE);

    // Transfer sequencer: all bus and response outputs are registered here
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= c_S_IDLE;
            r_count   <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (req_valid) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= req_we;
                        wbm_sel_o <= req_sel;
                        wbm_adr_o <= req_adr;
                        wbm_dat_o <= req_dat;
                        r_count   <= 8'd1;
                        r_state   <= c_S_BUS;
                    end
                end
                c_S_BUS: begin
                    // ack wins over timeout when both occur on one edge
                    if (wbm_ack_i || (r_count == c_TIMEOUT)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~wbm_ack_i;
                        rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'd0;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'd0;
                        wbm_adr_o <= 32'd0;
                        wbm_dat_o <= 32'd0;
                        r_state   <= c_S_RESP;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                c_S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_dat   <= 32'd0;
                        rsp_err   <= 1'b0;
                        r_state   <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Purpose  : Directed bench for wb_cmd_master. Two instances (TIMEOUT 16 and
//            TIMEOUT 4) share one stimulus; a transaction-level model predicts
//            every output each cycle, and literal checks pin key results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    localparam int c_N = 2;
    localparam int c_TO [c_N] = '{16, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = 32'd0;
    logic [31:0] req_dat = 32'd0;
    logic [3:0]  req_sel = 4'd0;
    logic        rsp_ready = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] dat_i = 32'd0;

    logic        req_ready [c_N];
    logic        rsp_valid [c_N];
    logic [31:0] rsp_dat   [c_N];
    logic        rsp_err   [c_N];
    logic        cyc       [c_N];
    logic        stb       [c_N];
    logic        we        [c_N];
    logic [3:0]  sel       [c_N];
    logic [31:0] adr       [c_N];
    logic [31:0] dat_o     [c_N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < c_N; k++) begin : g_dut
            wb_cmd_master #(.TIMEOUT(c_TO[k])) dut (
                .wb_clk_i  (clk),
                .wb_rst_i  (rst),
                .req_valid (req_valid),
                .req_ready (req_ready[k]),
                .req_we    (req_we),
                .req_adr   (req_adr),
                .req_dat   (req_dat),
                .req_sel   (req_sel),
                .rsp_valid (rsp_valid[k]),
                .rsp_ready (rsp_ready),
                .rsp_dat   (rsp_dat[k]),
                .rsp_err   (rsp_err[k]),
                .wbm_cyc_o (cyc[k]),
                .wbm_stb_o (stb[k]),
                .wbm_we_o  (we[k]),
                .wbm_sel_o (sel[k]),
                .wbm_adr_o (adr[k]),
                .wbm_dat_o (dat_o[k]),
                .wbm_ack_i (ack),
                .wbm_dat_i (dat_i)
            );
        end
    endgenerate

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL t=%0t inst%0d %s actual=%h expected=%h", $time, k, name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: one command in flight, tracked by the edge
    // number it was accepted on; bus age is plain edge arithmetic.
    // ------------------------------------------------------------------
    int          edge_no = 0;
    bit          m_busy  [c_N];
    bit          m_have  [c_N];
    int          m_start [c_N];
    logic        m_we    [c_N];
    logic [31:0] m_adr   [c_N];
    logic [31:0] m_dat   [c_N];
    logic [3:0]  m_sel   [c_N];
    logic [31:0] m_rdat  [c_N];
    logic        m_rerr  [c_N];

    initial begin
        for (int k = 0; k < c_N; k++) begin
            m_busy[k] = 0; m_have[k] = 0; m_start[k] = 0;
            m_we[k] = 0; m_adr[k] = 0; m_dat[k] = 0; m_sel[k] = 0;
            m_rdat[k] = 0; m_rerr[k] = 0;
        end
    end

    always @(posedge clk) begin
        edge_no++;
        for (int k = 0; k < c_N; k++) begin
            if (rst) begin
                m_busy[k] = 0;
                m_have[k] = 0;
                m_rdat[k] = 0;
                m_rerr[k] = 0;
            end else if (m_have[k]) begin
                if (rsp_ready) begin
                    m_have[k] = 0;
                    m_rdat[k] = 0;
                    m_rerr[k] = 0;
                end
            end else if (m_busy[k]) begin
                if (ack) begin
                    m_busy[k] = 0; m_have[k] = 1; m_rerr[k] = 0;
                    m_rdat[k] = m_we[k] ? 32'd0 : dat_i;
                end else if (edge_no - m_start[k] >= c_TO[k]) begin
                    m_busy[k] = 0; m_have[k] = 1; m_rerr[k] = 1; m_rdat[k] = 32'd0;
                end
            end else if (req_valid) begin
                m_busy[k] = 1; m_start[k] = edge_no;
                m_we[k] = req_we; m_adr[k] = req_adr; m_dat[k] = req_dat; m_sel[k] = req_sel;
            end
        end
    end

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin
        for (int k = 0; k < c_N; k++) begin
            chk(k, "req_ready", 32'(req_ready[k]), 32'(!m_busy[k] && !m_have[k]));
            chk(k, "rsp_valid", 32'(rsp_valid[k]), 32'(m_have[k]));
            chk(k, "rsp_dat",   rsp_dat[k], m_have[k] ? m_rdat[k] : 32'd0);
            chk(k, "rsp_err",   32'(rsp_err[k]), 32'(m_have[k] && m_rerr[k]));
            chk(k, "cyc",       32'(cyc[k]), 32'(m_busy[k]));
            chk(k, "stb",       32'(stb[k]), 32'(m_busy[k]));
            chk(k, "we",        32'(we[k]),  32'(m_busy[k] && m_we[k]));
            chk(k, "sel",       32'(sel[k]), m_busy[k] ? 32'(m_sel[k]) : 32'd0);
            chk(k, "adr",       adr[k],   m_busy[k] ? m_adr[k] : 32'd0);
            chk(k, "dat_o",     dat_o[k], m_busy[k] ? m_dat[k] : 32'd0);
        end
    end

    // Length of the most recent run of cyc-high cycles per instance
    int run_len  [c_N] = '{0, 0};
    int last_len [c_N] = '{0, 0};
    always @(posedge clk) begin
        for (int k = 0; k < c_N; k++) begin
            if (cyc[k] === 1'b1) run_len[k]++;
            else if (run_len[k] > 0) begin
                last_len[k] = run_len[k];
                run_len[k] = 0;
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1; req_we = w; req_adr = a; req_dat = d; req_sel = s;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_adr = 32'd0; req_dat = 32'd0; req_sel = 4'd0;
    endtask

    int accepts;

    initial begin
        step(2);
        rst = 1'b0;
        // reset state
        chk(0, "rst req_ready", 32'(req_ready[0]), 32'd1);
        chk(0, "rst cyc",       32'(cyc[0]), 32'd0);
        chk(0, "rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        step();

        // write with wait states: ack in 3rd BUS cycle
        issue(1'b1, 32'h3000_0000, 32'h0000_0005, 4'hF);
        chk(0, "wr cyc", 32'(cyc[0]), 32'd1);
        chk(0, "wr we",  32'(we[0]), 32'd1);
        chk(0, "wr dat", dat_o[0], 32'h5);
        step(2);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk(0, "wr rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk(0, "wr rsp_err",   32'(rsp_err[0]), 32'd0);
        chk(0, "wr rsp_dat",   rsp_dat[0], 32'd0);
        chk(0, "wr cyc after", 32'(cyc[0]), 32'd0);
        step();
        chk(0, "wr cyc len", 32'(last_len[0]), 32'd3);

        // zero-wait read
        issue(1'b0, 32'h3000_0004, 32'd0, 4'hF);
        ack = 1'b1; dat_i = 32'hDEAD_BEEF;
        step();
        ack = 1'b0; dat_i = 32'd0;
        chk(0, "rd rsp_dat", rsp_dat[0], 32'hDEAD_BEEF);
        chk(0, "rd rsp_err", 32'(rsp_err[0]), 32'd0);
        step();
        chk(0, "rd cyc len", 32'(last_len[0]), 32'd1);

        // timeout with a late ack two cycles after it
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0008, 32'd0, 4'hF);
        step(16);
        chk(0, "to rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk(0, "to rsp_err",   32'(rsp_err[0]), 32'd1);
        chk(0, "to rsp_dat",   rsp_dat[0], 32'd0);
        step();
        ack = 1'b1; dat_i = 32'h5555_AAAA;
        step();
        ack = 1'b0; dat_i = 32'd0;
        chk(0, "late ack err", 32'(rsp_err[0]), 32'd1);
        chk(0, "late ack dat", rsp_dat[0], 32'd0);
        chk(0, "to cyc len",   32'(last_len[0]), 32'd16);
        chk(1, "to cyc len",   32'(last_len[1]), 32'd4);
        rsp_ready = 1'b1;
        step();

        // response backpressure
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_000C, 32'd0, 4'h3);
        ack = 1'b1; dat_i = 32'hA5A5_5A5A;
        step();
        ack = 1'b0; dat_i = 32'd0;
        for (int i = 0; i < 4; i++) begin
            chk(0, "bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk(0, "bp rsp_dat",   rsp_dat[0], 32'hA5A5_5A5A);
            chk(0, "bp req_ready", 32'(req_ready[0]), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk(0, "bp idle", 32'(req_ready[0]), 32'd1);

        // reset in the 2nd BUS cycle
        issue(1'b1, 32'h3000_0010, 32'h0000_00FF, 4'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk(0, "mrst cyc",       32'(cyc[0]), 32'd0);
        chk(0, "mrst adr",       adr[0], 32'd0);
        chk(0, "mrst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk(0, "mrst req_ready", 32'(req_ready[0]), 32'd1);
        step();

        // ack and timeout on the same edge (TIMEOUT = 4 instance)
        issue(1'b0, 32'h3000_0014, 32'd0, 4'hF);
        step(3);
        ack = 1'b1; dat_i = 32'h0000_1234;
        step();
        ack = 1'b0; dat_i = 32'd0;
        chk(1, "tie rsp_err", 32'(rsp_err[1]), 32'd0);
        chk(1, "tie rsp_dat", rsp_dat[1], 32'h0000_1234);
        step();

        // back-to-back commands, zero-wait slave, rsp_ready tied high
        accepts = 0;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0018; req_sel = 4'hF;
        ack = 1'b1; dat_i = 32'h0BAD_F00D;
        for (int i = 0; i < 9; i++) begin
            if (req_ready[0] === 1'b1) accepts++;
            step();
        end
        req_valid = 1'b0; ack = 1'b0; dat_i = 32'd0;
        chk(0, "b2b accepts", 32'(accepts), 32'd3);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
